// File: rtl/mfp_mac_sym_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_mac_sym_stream_if
//  Description : Sample stream, coefficient write port and result stream of
//                the streaming symmetric FIR. Optional saturation-flag
//                signals exist only when MFP_MAC_SAT_FLAG_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface mfp_mac_sym_stream_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ARR_L  = 19,
    parameter int CH     = 1
);
    localparam int c_NH     = (ARR_L + 1) / 2;
    localparam int c_ADDR_W = (c_NH > 1) ? $clog2(c_NH) : 1;
    localparam int c_CH_W   = (CH > 1) ? $clog2(CH) : 1;

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                coef_we;
    logic [c_ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0]   coef_data;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [c_CH_W-1:0]   out_ch;
`ifdef MFP_MAC_SAT_FLAG_EN
    logic                sat_clr;
    logic                sat_flag;
`endif

    // Stream source / coefficient writer side
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  out_valid, out_data, out_ch
`ifdef MFP_MAC_SAT_FLAG_EN
        , output sat_clr
        , input  sat_flag
`endif
    );

    // Filter side
    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output out_valid, out_data, out_ch
`ifdef MFP_MAC_SAT_FLAG_EN
        , input  sat_clr
        , output sat_flag
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mfp_mac_sym_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_mac_sym_stream
//  Description : Streaming symmetric FIR over CH time-interleaved channels.
//                Pre-add of mirrored taps, unsigned-coefficient multiply,
//                full-precision accumulate, round (or floor), shift and
//                saturate. Three-cycle latency from accepted sample to result.
//                Optional sticky saturation flag: MFP_MAC_SAT_FLAG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mfp_mac_sym_stream #(
    parameter int DATA_W      = 8,
    parameter int COEF_W      = 8,
    parameter int COEF_FRAC_W = 6,
    parameter int ARR_L       = 19,
    parameter int CH          = 1,
    parameter int IS_UNSIGNED = 1,
    parameter int IS_FLOOR    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mfp_mac_sym_stream_if.slave  bus
);
    localparam int c_NH     = (ARR_L + 1) / 2;
    localparam int c_CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int c_WIN_N  = CH * (ARR_L - 1);          // stored history; entry 0 is in_data
    localparam int c_PRE_W  = DATA_W + 2;                // extra bit lets both sample modes share a signed path
    localparam int c_PROD_W = c_PRE_W + COEF_W + 1;
    localparam int c_ACC_W  = DATA_W + 1 + COEF_W + $clog2(c_NH);
    localparam int c_SUM_W  = c_ACC_W + 2;               // headroom for signed form and rounding constant
    localparam int c_MAX_I  = (IS_UNSIGNED != 0) ? (1 << DATA_W) - 1 : (1 << (DATA_W - 1)) - 1;
    localparam int c_MIN_I  = (IS_UNSIGNED != 0) ? 0 : -(1 << (DATA_W - 1));
    localparam logic signed [c_SUM_W-1:0] c_MAX = c_SUM_W'(c_MAX_I);
    localparam logic signed [c_SUM_W-1:0] c_MIN = c_SUM_W'(c_MIN_I);
    localparam logic signed [c_SUM_W-1:0] c_RND =
        c_SUM_W'((IS_FLOOR != 0) ? 0 : (1 << (COEF_FRAC_W - 1)));
    localparam logic [DATA_W-1:0] c_MAX_D  = DATA_W'(c_MAX_I);
    localparam logic [DATA_W-1:0] c_MIN_D  = DATA_W'(c_MIN_I);
    localparam logic [COEF_W-1:0] c_COEF_ONE = COEF_W'(1 << COEF_FRAC_W);

    // Sign- or zero-extend a sample into the shared signed pre-add width
    function automatic logic signed [c_PRE_W-1:0] ext(input logic [DATA_W-1:0] x);
        if (IS_UNSIGNED != 0) ext = {2'b00, x};
        else                  ext = {{2{x[DATA_W-1]}}, x};
    endfunction

    logic [DATA_W-1:0]          r_win [c_WIN_N];
    logic [c_CH_W-1:0]          r_in_ch;
    logic [COEF_W-1:0]          r_coef [c_NH];
    logic [DATA_W-1:0]          w_tap [ARR_L];
    logic signed [c_PRE_W-1:0]  w_pre [c_NH];
    logic signed [c_PRE_W-1:0]  r_pre [c_NH];
    logic                       r_vld1;
    logic [c_CH_W-1:0]          r_ch1;
    logic signed [c_PROD_W-1:0] w_prod [c_NH];
    logic signed [c_PROD_W-1:0] r_prod [c_NH];
    logic                       r_vld2;
    logic [c_CH_W-1:0]          r_ch2;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic signed [c_SUM_W-1:0]  w_shr;
    logic [DATA_W-1:0]          w_sat;
    logic                       r_out_valid;
    logic [DATA_W-1:0]          r_out_data;
    logic [c_CH_W-1:0]          r_out_ch;

    // Sample history: shifts only on accepted samples
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_WIN_N; k++) r_win[k] <= '0;
        end else if (bus.in_valid) begin
            r_win[0] <= bus.in_data;
            for (int k = 1; k < c_WIN_N; k++) r_win[k] <= r_win[k-1];
        end
    end

    // Channel of the incoming sample, wraps CH-1 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ch <= '0;
        end else if (bus.in_valid) begin
            if (r_in_ch == c_CH_W'(CH - 1)) r_in_ch <= '0;
            else                            r_in_ch <= r_in_ch + c_CH_W'(1);
        end
    end

    // Coefficient table: identity after reset, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NH; i++) r_coef[i] <= (i == c_NH - 1) ? c_COEF_ONE : '0;
        end else if (bus.coef_we && (int'(bus.coef_addr) < c_NH)) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Taps of the window that includes the sample arriving this cycle
    always_comb begin
        w_tap[0] = bus.in_data;
        for (int j = 1; j < ARR_L; j++) w_tap[j] = r_win[j*CH-1];
        for (int i = 0; i < c_NH - 1; i++) w_pre[i] = ext(w_tap[i]) + ext(w_tap[ARR_L-1-i]);
        w_pre[c_NH-1] = ext(w_tap[c_NH-1]);
    end

    // Stage 1: register mirrored-pair sums with valid and channel tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NH; i++) r_pre[i] <= '0;
            r_vld1 <= 1'b0;
            r_ch1  <= '0;
        end else begin
            for (int i = 0; i < c_NH; i++) r_pre[i] <= w_pre[i];
            r_vld1 <= bus.in_valid;
            r_ch1  <= r_in_ch;
        end
    end

    // Multiply by the coefficient held this cycle (zero-extended, always unsigned)
    always_comb begin
        for (int i = 0; i < c_NH; i++) w_prod[i] = r_pre[i] * $signed({1'b0, r_coef[i]});
    end

    // Stage 2: register products
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NH; i++) r_prod[i] <= '0;
            r_vld2 <= 1'b0;
            r_ch2  <= '0;
        end else begin
            for (int i = 0; i < c_NH; i++) r_prod[i] <= w_prod[i];
            r_vld2 <= r_vld1;
            r_ch2  <= r_ch1;
        end
    end

    // Full-precision sum with rounding constant, shift, then clamp to output range
    always_comb begin
        w_sum = c_RND;
        for (int i = 0; i < c_NH; i++)
            w_sum = w_sum + $signed({{(c_SUM_W-c_PROD_W){r_prod[i][c_PROD_W-1]}}, r_prod[i]});
        w_shr = w_sum >>> COEF_FRAC_W;
        if (w_shr > c_MAX)      w_sat = c_MAX_D;
        else if (w_shr < c_MIN) w_sat = c_MIN_D;
        else                    w_sat = w_shr[DATA_W-1:0];
    end

    // Stage 3: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
            r_out_valid <= r_vld2;
            r_out_data  <= w_sat;
            r_out_ch    <= r_ch2;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

`ifdef MFP_MAC_SAT_FLAG_EN
    logic w_clamp;
    logic r_sat_flag;

    assign w_clamp = (w_shr > c_MAX) || (w_shr < c_MIN);

    // Sticky clamp indicator; a new clamp outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst)                   r_sat_flag <= 1'b0;
        else if (r_vld2 && w_clamp) r_sat_flag <= 1'b1;
        else if (bus.sat_clr)      r_sat_flag <= 1'b0;
    end

    assign bus.sat_flag = r_sat_flag;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mfp_mac_sym_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfp_mac_sym_stream
//  Description : Scoreboard bench for mfp_mac_sym_stream. Two instances share
//                one stimulus stream: A = unsigned/round, B = signed/floor,
//                both ARR_L=5, CH=2. A direct-form reference FIR produces the
//                expected result and due cycle of every accepted sample.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfp_mac_sym_stream;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int FRAC_W = 6;
    localparam int ARR_L  = 5;
    localparam int CH     = 2;
    localparam int NH     = (ARR_L + 1) / 2;

    typedef struct {
        int data;
        int ch;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_valid = 1'b0;
    logic [7:0] d_data  = '0;
    logic       d_we    = 1'b0;
    logic [1:0] d_addr  = '0;
    logic [7:0] d_cdata = '0;
    bit         mon_en  = 1'b0;
    int         cyc     = 0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         hist [CH][ARR_L];
    int         coef_m [NH];
    int         ch_m;
    exp_t       q_a[$];
    exp_t       q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mfp_mac_sym_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ARR_L(ARR_L), .CH(CH)) bus_a ();
    mfp_mac_sym_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ARR_L(ARR_L), .CH(CH)) bus_b ();

    assign bus_a.in_valid  = d_valid;
    assign bus_a.in_data   = d_data;
    assign bus_a.coef_we   = d_we;
    assign bus_a.coef_addr = d_addr;
    assign bus_a.coef_data = d_cdata;
    assign bus_b.in_valid  = d_valid;
    assign bus_b.in_data   = d_data;
    assign bus_b.coef_we   = d_we;
    assign bus_b.coef_addr = d_addr;
    assign bus_b.coef_data = d_cdata;
`ifdef MFP_MAC_SAT_FLAG_EN
    logic d_sat_clr = 1'b0;
    assign bus_a.sat_clr = d_sat_clr;
    assign bus_b.sat_clr = d_sat_clr;
`endif

    mfp_mac_sym_stream #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC_W(FRAC_W), .ARR_L(ARR_L),
        .CH(CH), .IS_UNSIGNED(1), .IS_FLOOR(0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mfp_mac_sym_stream #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC_W(FRAC_W), .ARR_L(ARR_L),
        .CH(CH), .IS_UNSIGNED(0), .IS_FLOOR(1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d", tag, act, act, exp, exp, cyc);
        end
    endtask

    // Reference direct-form FIR over the per-channel history
    function automatic int model_out(input bit uns, input bit flr, input int c);
        int acc;
        int v;
        int k;
        int res;
        acc = 0;
        for (int j = 0; j < ARR_L; j++) begin
            v = hist[c][j];
            if (!uns && v >= 128) v = v - 256;
            k = (j < ARR_L - 1 - j) ? j : ARR_L - 1 - j;
            acc = acc + v * coef_m[k];
        end
        if (!flr) acc = acc + (1 << (FRAC_W - 1));
        res = acc >>> FRAC_W;
        if (uns) begin
            if (res > 255) res = 255;
            if (res < 0)   res = 0;
        end else begin
            if (res > 127)  res = 127;
            if (res < -128) res = -128;
        end
        return res & 255;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < ARR_L; j++) hist[c][j] = 0;
        for (int i = 0; i < NH; i++) coef_m[i] = (i == NH - 1) ? (1 << FRAC_W) : 0;
        ch_m = 0;
    endtask

    // One cycle of stimulus; the expected result is queued with its due cycle
    task automatic step(input bit v, input int d, input bit we, input int a, input int cd);
        exp_t e;
        @(negedge clk);
        d_valid = v;
        d_data  = d[7:0];
        d_we    = we;
        d_addr  = a[1:0];
        d_cdata = cd[7:0];
        if (we && a < NH) coef_m[a] = cd & 255;
        if (v) begin
            for (int j = ARR_L - 1; j > 0; j--) hist[ch_m][j] = hist[ch_m][j-1];
            hist[ch_m][0] = d & 255;
            e.ch  = ch_m;
            e.due = cyc + 3;
            e.data = model_out(1'b1, 1'b0, ch_m);
            q_a.push_back(e);
            e.data = model_out(1'b0, 1'b1, ch_m);
            q_b.push_back(e);
            ch_m = (ch_m + 1) % CH;
        end
    endtask

    task automatic send(input int d);
        step(1'b1, d, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0);
    endtask

    // One-cycle reset; a coefficient write presented alongside must lose
    task automatic pulse_reset();
        @(negedge clk);
        rst     = 1'b1;
        d_valid = 1'b0;
        d_we    = 1'b1;
        d_addr  = 2'd2;
        d_cdata = 8'd0;
        while (q_a.size() > 0 && q_a[q_a.size()-1].due > cyc) q_a.delete(q_a.size()-1);
        while (q_b.size() > 0 && q_b[q_b.size()-1].due > cyc) q_b.delete(q_b.size()-1);
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic mon_port(input int which, input logic v, input logic [7:0] d, input logic [0:0] c);
        exp_t  e;
        bit    have;
        string nm;
        nm   = (which == 0) ? "a" : "b";
        have = (which == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        if (have) begin
            if (which == 0) e = q_a[0];
            else            e = q_b[0];
        end
        if (v === 1'b1) begin
            if (!have) begin
                check_val({nm, "_unexpected_valid"}, 32'(v), 32'd0);
            end else begin
                if (which == 0) q_a.delete(0);
                else            q_b.delete(0);
                check_val({nm, "_data"}, 32'(d), e.data);
                check_val({nm, "_ch"}, 32'(c), e.ch);
                check_val({nm, "_latency"}, cyc, e.due);
            end
        end else if (have && e.due <= cyc) begin
            if (which == 0) q_a.delete(0);
            else            q_b.delete(0);
            check_val({nm, "_missing_valid"}, 32'(v), 32'd1);
        end
    endtask

    // Scoreboard side: compare every cycle away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            mon_port(0, bus_a.out_valid, bus_a.out_data, bus_a.out_ch);
            mon_port(1, bus_b.out_valid, bus_b.out_data, bus_b.out_ch);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_val("a_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("a_rst_data",  32'(bus_a.out_data),  32'd0);
        check_val("a_rst_ch",    32'(bus_a.out_ch),    32'd0);
        check_val("b_rst_valid", 32'(bus_b.out_valid), 32'd0);
        check_val("b_rst_data",  32'(bus_b.out_data),  32'd0);
        check_val("b_rst_ch",    32'(bus_b.out_ch),    32'd0);
`ifdef MFP_MAC_SAT_FLAG_EN
        check_val("a_rst_sat_flag", 32'(bus_a.sat_flag), 32'd0);
        check_val("b_rst_sat_flag", 32'(bus_b.sat_flag), 32'd0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;

        // Identity impulse
        send(200);
        for (int i = 0; i < 11; i++) send(0);
        idle(4);

        // Box filter, rounding vs floor
        for (int a = 0; a < NH; a++) step(1'b0, 0, 1'b1, a, 13);
        for (int i = 0; i < 20; i++) send(100);
        idle(4);

        // Saturation, both directions
        for (int a = 0; a < NH; a++) step(1'b0, 0, 1'b1, a, 64);
        for (int i = 0; i < 14; i++) send(100);
        for (int i = 0; i < 14; i++) send(-100);
        idle(5);
`ifdef MFP_MAC_SAT_FLAG_EN
        check_val("a_sat_flag_set", 32'(bus_a.sat_flag), 32'd1);
        check_val("b_sat_flag_set", 32'(bus_b.sat_flag), 32'd1);
        @(negedge clk);
        d_sat_clr = 1'b1;
        @(negedge clk);
        d_sat_clr = 1'b0;
        check_val("a_sat_flag_clr", 32'(bus_a.sat_flag), 32'd0);
        check_val("b_sat_flag_clr", 32'(bus_b.sat_flag), 32'd0);
`endif

        // Reset with samples in flight; coefficients return to identity
        send(77);
        send(5);
        send(140);
        pulse_reset();
        idle(2);

        // Out-of-range coefficient address is ignored
        step(1'b0, 0, 1'b1, 3, 99);

        // Interleaved channels under identity
        for (int i = 0; i < 8; i++) begin
            send(10);
            send(250);
        end
        idle(4);

        // Gapped stream with a coefficient change mid-stream
        step(1'b0, 0, 1'b1, 0, 5);
        step(1'b0, 0, 1'b1, 1, 20);
        step(1'b0, 0, 1'b1, 2, 30);
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 30 + 40 * r, 1'b0, 0, 0);
            step(1'b0, 0, 1'b0, 0, 0);
            step(1'b1, 200 - 17 * r, (r == 2), 1, 9);
            step(1'b1, 90 + r, 1'b0, 0, 0);
            step(1'b0, 0, 1'b0, 0, 0);
        end
        idle(4);

        // Random traffic with occasional coefficient writes
        for (int i = 0; i < 80; i++)
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 80)));
        idle(8);

        check_val("a_queue_drained", q_a.size(), 32'd0);
        check_val("b_queue_drained", q_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
